// File: rtl/parity_encoder_gate_if.sv
// Nibble-side bundle for parity_encoder_gate: accept strobe, parity sense,
// data bits and the registered parity/frame results.
interface parity_encoder_gate_if;
  logic en;
  logic odd_sel;
  logic a;
  logic b;
  logic c;
  logic d;
  logic P;
  logic P_valid;
  logic frame_P;
  logic frame_done;

  modport master (
    output en, odd_sel, a, b, c, d,
    input  P, P_valid, frame_P, frame_done
  );

  modport slave (
    input  en, odd_sel, a, b, c, d,
    output P, P_valid, frame_P, frame_done
  );
endinterface

// File: rtl/parity_encoder_gate.sv
// Registered 4-bit parity encoder with per-cycle even/odd sense and a
// frame-level parity folded over FRAME_LEN accepted nibbles.
module parity_encoder_gate #(
  parameter int unsigned FRAME_LEN = 8
) (
  input logic                  clk,
  input logic                  rst,
  parity_encoder_gate_if.slave bus
);
  localparam int unsigned          CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(FRAME_LEN - 1);

  logic w_a, w_b, w_c, w_d, w_en, w_odd;
  logic w_ab, w_cd, w_x, w_last;

  logic             r_p;
  logic             r_p_valid;
  logic             r_frame_p;
  logic             r_frame_done;
  logic             r_acc;
  logic [CNT_W-1:0] r_cnt;

  assign w_a   = bus.a;
  assign w_b   = bus.b;
  assign w_c   = bus.c;
  assign w_d   = bus.d;
  assign w_en  = bus.en;
  assign w_odd = bus.odd_sel;

  // Balanced two-level XOR tree built from gate primitives.
  xor u_xor_ab  (w_ab, w_a, w_b);
  xor u_xor_cd  (w_cd, w_c, w_d);
  xor u_xor_all (w_x, w_ab, w_cd);

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p          <= 1'b0;
      r_p_valid    <= 1'b0;
      r_frame_p    <= 1'b0;
      r_frame_done <= 1'b0;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
    end else if (w_en) begin
      r_p       <= w_x ^ w_odd;
      r_p_valid <= 1'b1;
      if (w_last) begin
        // Only the final nibble's odd_sel shapes the frame parity.
        r_frame_p    <= r_acc ^ w_x ^ w_odd;
        r_frame_done <= 1'b1;
        r_acc        <= 1'b0;
        r_cnt        <= '0;
      end else begin
        r_acc        <= r_acc ^ w_x;
        r_cnt        <= r_cnt + CNT_W'(1);
        r_frame_done <= 1'b0;
      end
    end else begin
      r_p_valid    <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign bus.P          = r_p;
  assign bus.P_valid    = r_p_valid;
  assign bus.frame_P    = r_frame_p;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_parity_encoder_gate.sv
// Scoreboard bench for parity_encoder_gate: directed test-plan sequences plus
// random traffic, checked against a count-of-ones reference model.
module tb_parity_encoder_gate;
  localparam int unsigned FL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_encoder_gate_if bus0 ();
  parity_encoder_gate_if bus1 ();

  parity_encoder_gate #(.FRAME_LEN(FL)) dut (.clk(clk), .rst(rst), .bus(bus0.slave));
  parity_encoder_gate #(.FRAME_LEN(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct packed {
    logic p;
    logic fd;
    logic fp;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] frame_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic m_p = 1'b0;
  logic m_fp = 1'b0;
  logic m_valid = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic o, input logic [3:0] n);
    int   ones;
    logic x;
    logic fd;
    @(negedge clk);
    rst = r;
    bus0.en = e; bus0.odd_sel = o;
    {bus0.a, bus0.b, bus0.c, bus0.d} = n;
    bus1.en = e; bus1.odd_sel = o;
    {bus1.a, bus1.b, bus1.c, bus1.d} = n;
    if (r) begin
      m_p = 1'b0; m_fp = 1'b0; m_valid = 1'b0;
      frame_q.delete();
    end else if (e) begin
      x = logic'($countones(n) % 2);
      m_p = x ^ o;
      m_valid = 1'b1;
      frame_q.push_back(n);
      fd = 1'b0;
      if (frame_q.size() == FL) begin
        ones = 0;
        foreach (frame_q[i]) ones += $countones(frame_q[i]);
        m_fp = logic'(ones % 2) ^ o;
        fd = 1'b1;
        frame_q.delete();
      end
      exp_q.push_back('{p: m_p, fd: fd, fp: m_fp});
    end else begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus0.P_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_P_valid", bus0.P_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("P", bus0.P, e.p);
            chk("frame_done", bus0.frame_done, e.fd);
            chk("frame_P", bus0.frame_P, e.fp);
          end
        end else begin
          chk("P_valid_low", bus0.P_valid, m_valid);
          chk("P_hold", bus0.P, m_p);
          chk("frame_done_idle", bus0.frame_done, 1'b0);
          chk("frame_P_hold", bus0.frame_P, m_fp);
        end
        chk("fl1_P", bus1.P, m_p);
        chk("fl1_P_valid", bus1.P_valid, m_valid);
        chk("fl1_frame_P", bus1.frame_P, m_p);
        chk("fl1_frame_done", bus1.frame_done, m_valid);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq8 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b0000, 4'b1000, 4'b1100, 4'b1110};
    bus0.en = 1'b0; bus0.odd_sel = 1'b0; {bus0.a, bus0.b, bus0.c, bus0.d} = 4'b0;
    bus1.en = 1'b0; bus1.odd_sel = 1'b0; {bus1.a, bus1.b, bus1.c, bus1.d} = 4'b0;
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'b0000);

    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 1'b0, 4'(v));
    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 1'b1, 4'(v));

    step(1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));

    step(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, seq8[k]);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, (k == 7), seq8[k]);
    step(1'b0, 1'b0, 1'b0, 4'b0000);

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 4'b0000);

    step(1'b1, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 4'b0000);

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(99) < 2), 1'($urandom_range(99) < 75),
           1'($urandom_range(1)), 4'($urandom_range(15)));

    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/parity_encoder_gate.md
# parity_encoder_gate

Registered 4-bit parity encoder with frame-level parity accumulation. Each accepted nibble {a,b,c,d} produces a parity bit P, with even or odd sense selected per cycle. Successive nibble parities are folded into a frame parity bit every FRAME_LEN accepted nibbles. The block sits at the edge of a serial/nibble datapath and generates check bits for downstream transmission or storage.

## Interface
- FRAME_LEN, default 8: accepted nibbles per frame; legal range 1..255.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  accept strobe; the nibble is sampled only when en=1.
- odd_sel  input  1  0 = even parity, 1 = odd parity; sampled together with the nibble.
- a  input  1  data bit 3 (MSB).
- b  input  1  data bit 2.
- c  input  1  data bit 1.
- d  input  1  data bit 0 (LSB).
- P  output  1  registered parity of the last accepted nibble.
- P_valid  output  1  high for exactly one cycle after each accepted nibble.
- frame_P  output  1  registered parity of the last completed frame.
- frame_done  output  1  one-cycle pulse when frame_P updates.

## Operation
- Nibble parity: x = a^b^c^d. Build the XOR tree from gate-level XOR primitives; use no reduction operator on a vector.
- Even mode (odd_sel=0): P = x, so the total count of ones in {a,b,c,d,P} is even.
- Odd mode (odd_sel=1): P = ~x, so the total count of ones is odd.
- On each clock with en=1: P <= x ^ odd_sel and P_valid <= 1.
- On each clock with en=0: P holds and P_valid <= 0.
- Frame accumulator acc is 1 bit, the XOR of x over accepted nibbles. Count cnt is ceil(log2(FRAME_LEN+1)) bits wide.
- Accepted nibble when cnt < FRAME_LEN-1: acc <= acc ^ x, cnt <= cnt+1, frame_done <= 0.
- Accepted nibble when cnt == FRAME_LEN-1 (frame end):
  - frame_P <= acc ^ x ^ odd_sel, where odd_sel is taken from the final nibble's cycle.
  - frame_done <= 1.
  - acc <= 0 and cnt <= 0.
- frame_done is 0 on every cycle that is not a frame end. frame_P holds between frames.
- FRAME_LEN=1: every accepted nibble ends a frame, so frame_P equals P and frame_done equals P_valid.
- Outputs depend only on registered state; there are no combinational input-to-output paths.

## Timing
- Reset (rst=1 at a rising edge): P=0, P_valid=0, frame_P=0, frame_done=0, acc=0, cnt=0.
- rst has priority over en. A nibble presented in a reset cycle is discarded.
- Reset mid-frame aborts the frame. The partial acc is lost, and the next accepted nibble starts a new frame.
- Latency is one cycle. A nibble sampled at edge N appears on P and P_valid after edge N; frame_P and frame_done update at that same edge.
- Back-to-back en=1 is fully supported at one nibble per cycle with no stall; P_valid stays high continuously.
- Inputs changing while en=0 have no effect on any output or internal state.
- odd_sel may change on any cycle and affects only the cycle in which it is sampled.

## Test plan
- Exhaustive even mode: apply abcd = 0000..1111 in order with en=1 and odd_sel=0.
  - Required P sequence, one cycle later each: 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0.
  - P_valid stays high throughout.
- Exhaustive odd mode: repeat the same 16 vectors with odd_sel=1.
  - Required P sequence: 1,0,0,1,0,1,1,0,0,1,1,0,1,0,0,1.
- Hold behaviour:
  - Accept abcd=0001, giving P=1.
  - Drop en and toggle the inputs for 5 cycles.
  - Required: P stays 1, P_valid=0, no frame_done pulse.
- Frame parity with FRAME_LEN=8, even mode:
  - Feed nibbles 0001,0011,0111,1111,0000,1000,1100,1110, whose x values are 1,0,1,0,0,1,0,1.
  - Required: frame_P=0 and frame_done pulses exactly once, on the cycle after the 8th nibble.
  - Repeat with odd_sel=1 on the 8th nibble; required frame_P=1.
- Reset mid-frame:
  - Feed 3 nibbles with x=1, assert rst for 1 cycle, then feed 8 nibbles of 0001.
  - Required: all outputs read 0 after the reset edge.
  - The frame completes only after the 8th post-reset nibble, with frame_P=0 in even mode.
- Reset priority: assert rst and en together with abcd=0001. Required: P=0 and P_valid=0 on the following cycle.
